// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types and defaults for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

    localparam int DEF_REG_ADDR_W = 3;
    localparam int DEF_MC_LAT     = 4;

    typedef enum logic [1:0] {RUN, MULTI, HALT_DRAIN, HALTED} state_t;

    typedef struct packed {
        logic [DEF_REG_ADDR_W-1:0] rd;
        logic                      wr;
    } slot_t;

    function automatic logic slot_hit(slot_t s, logic [DEF_REG_ADDR_W-1:0] r);
        return s.wr && (s.rd == r);
    endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: tracks destinations in EX and MEM and flags RAW hazards for the ID instruction.
module pipe_scoreboard
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_wr,
    input  logic                  id_ex_en,
    input  logic                  id_ex_bubble,
    input  logic                  ex_mem_en,
    input  logic                  ex_mem_bubble,
    output logic                  hazard
);

    slot_t ex_slot, mem_slot;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_slot  <= '0;
            mem_slot <= '0;
        end else begin
            if (id_ex_en && id_ex_bubble) ex_slot.wr <= 1'b0;
            else if (id_ex_en) ex_slot <= {id_rd, id_wr & id_valid};
            if (ex_mem_en && ex_mem_bubble) mem_slot.wr <= 1'b0;
            else if (ex_mem_en) mem_slot <= ex_slot;
        end
    end

    // WB never hazards: the register file writes before it reads
    assign hazard = id_valid &
        ((id_use_rs1 & (slot_hit(ex_slot, id_rs1) | slot_hit(mem_slot, id_rs1))) |
         (id_use_rs2 & (slot_hit(ex_slot, id_rs2) | slot_hit(mem_slot, id_rs2))));

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipeline.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int MC_LAT     = DEF_MC_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_wr,
    input  logic                  id_multi,
    input  logic                  id_halt,
    input  logic                  ex_branch_taken,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_bubble,
    output logic                  halted
);

    localparam int CW = ($clog2(MC_LAT) > 2) ? $clog2(MC_LAT) : 2;

    state_t         state, state_d;
    logic [CW-1:0]  cnt, cnt_d;
    logic           hazard, run;

    pipe_scoreboard #(.REG_ADDR_W(REG_ADDR_W)) u_sb (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_wr(id_wr),
        .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble),
        .ex_mem_en(ex_mem_en), .ex_mem_bubble(ex_mem_bubble),
        .hazard(hazard)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        halted        = 1'b0;
        state_d       = state;
        cnt_d         = cnt;
        run           = (state == RUN) || (state == MULTI && cnt == '0);
        if (rst) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_bubble = 1'b1;
        end else if (state == HALTED) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            halted    = 1'b1;
        end else if (state == HALT_DRAIN) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
            cnt_d        = cnt - 1'b1;
            state_d      = (cnt <= CW'(1)) ? HALTED : HALT_DRAIN;
        end else if (!run) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_bubble = 1'b1;
            cnt_d         = cnt - 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = RUN;
        end else if (hazard) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
            state_d      = RUN;
        end else begin
            // the op entering EX now occupies it this cycle plus MC_LAT-1 held cycles
            state_d = (id_valid && id_multi) ? MULTI : (id_valid && id_halt) ? HALT_DRAIN : RUN;
            cnt_d   = (id_valid && id_multi) ? CW'(MC_LAT - 1) : (id_valid && id_halt) ? CW'(2) : '0;
        end
    end

endmodule
